// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Issue-side controller for a combinational ALU. A request (ALUOp/Funct/A/B)
//   is accepted over a valid/ready handshake and decoded to the 4-bit ALU
//   select. Registered Op1/Op2/Sel are held for the op's cycle budget. The
//   ALU output and zero flag are then captured into a result register, which
//   is returned over a valid/ready handshake.
//
//   Ports
//     clk, reset          clock; synchronous active-high reset
//     ReqValid/ReqReady   request handshake
//     ALUOp, Funct, A, B  request fields
//     Op1, Op2, Sel       registered ALU inputs (this block is their only driver)
//     AluOut, AluZF       combinational ALU result and zero flag
//     RspValid/RspReady   response handshake
//     Result, ZF          captured result and zero flag
//     IllegalOp, DivZero  response status flags
//
//   Optional feature: define ALU_ISSUE_PIPE_EN so that a response retiring in
//   DONE can accept the next request on the same edge. ReqReady then
//   includes DONE & RspReady.
module alu_issue_ctrl #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Op1,
  output logic [WIDTH-1:0] Op2,
  output logic [3:0]       Sel,
  input  logic [WIDTH-1:0] AluOut,
  input  logic             AluZF,
  output logic             RspValid,
  input  logic             RspReady,
  output logic [WIDTH-1:0] Result,
  output logic             ZF,
  output logic             IllegalOp,
  output logic             DivZero
);

  localparam int MAXC  = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             ill_pend;
  logic             dz_pend;

  logic [3:0]       dec_sel;
  logic             dec_ill;
  logic             dec_dz;
  logic [CNT_W-1:0] dec_cnt;
  logic             accept;

  // Decode of the request currently on the input bus. An illegal request
  // maps to AND with Op2 forced to zero, so the ALU yields 0 and ZF=1. Every
  // Sel the ALU sees is therefore a decoded value. A DIV by zero skips the
  // wait because its result is forced and does not come from the ALU.
  always_comb begin
    dec_sel = 4'b0000;
    dec_ill = 1'b0;
    dec_dz  = 1'b0;
    dec_cnt = '0;
    case (ALUOp)
      2'b00: dec_sel = 4'b0010;
      2'b01: dec_sel = 4'b0110;
      2'b10: begin
        case (Funct)
          6'b100000: dec_sel = 4'b0010;
          6'b100010: dec_sel = 4'b0110;
          6'b100100: dec_sel = 4'b0000;
          6'b100101: dec_sel = 4'b0001;
          6'b101010: dec_sel = 4'b0111;
          6'b011000: begin
            dec_sel = 4'b0101;
            dec_cnt = MUL_LAST;
          end
          6'b011010: begin
            dec_sel = 4'b1111;
            if (B == '0) dec_dz  = 1'b1;
            else         dec_cnt = DIV_LAST;
          end
          default: dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

`ifdef ALU_ISSUE_PIPE_EN
  assign ReqReady = (state == IDLE) || ((state == DONE) && RspReady);
`else
  assign ReqReady = (state == IDLE);
`endif

  assign accept = ReqValid && ReqReady;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      ill_pend  <= 1'b0;
      dz_pend   <= 1'b0;
      Op1       <= '0;
      Op2       <= '0;
      Sel       <= 4'b0000;
      Result    <= '0;
      ZF        <= 1'b0;
      IllegalOp <= 1'b0;
      DivZero   <= 1'b0;
      RspValid  <= 1'b0;
    end else if (accept) begin
      // Accept edge: this is the only place where the ALU inputs change.
      // It also retires any response still in DONE (pipelined build).
      Op1       <= A;
      Op2       <= dec_ill ? '0 : B;
      Sel       <= dec_sel;
      cnt       <= dec_cnt;
      ill_pend  <= dec_ill;
      dz_pend   <= dec_dz;
      IllegalOp <= 1'b0;
      DivZero   <= 1'b0;
      RspValid  <= 1'b0;
      state     <= EXEC;
    end else begin
      case (state)
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            Result    <= dz_pend ? '1 : AluOut;
            ZF        <= dz_pend ? 1'b0 : AluZF;
            IllegalOp <= ill_pend;
            DivZero   <= dz_pend;
            RspValid  <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (RspReady) begin
            RspValid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  localparam int W   = 32;
  localparam int MUL = 4;
  localparam int DIV = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          ReqValid;
  logic          ReqReady;
  logic [1:0]    ALUOp;
  logic [5:0]    Funct;
  logic [W-1:0]  A, B;
  logic [W-1:0]  Op1, Op2;
  logic [3:0]    Sel;
  logic [W-1:0]  AluOut;
  logic          AluZF;
  logic          RspValid;
  logic          RspReady;
  logic [W-1:0]  Result;
  logic          ZF;
  logic          IllegalOp;
  logic          DivZero;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.WIDTH(W), .MUL_CYCLES(MUL), .DIV_CYCLES(DIV)) dut (
    .clk(clk), .reset(reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ALUOp(ALUOp), .Funct(Funct), .A(A), .B(B),
    .Op1(Op1), .Op2(Op2), .Sel(Sel), .AluOut(AluOut), .AluZF(AluZF),
    .RspValid(RspValid), .RspReady(RspReady), .Result(Result), .ZF(ZF),
    .IllegalOp(IllegalOp), .DivZero(DivZero)
  );

  // Behavioural combinational ALU.
  always_comb begin
    case (Sel)
      4'b0010: AluOut = Op1 + Op2;
      4'b0110: AluOut = Op1 - Op2;
      4'b0000: AluOut = Op1 & Op2;
      4'b0001: AluOut = Op1 | Op2;
      4'b0111: AluOut = ($signed(Op1) < $signed(Op2)) ? 32'd1 : 32'd0;
      4'b0101: AluOut = Op1 * Op2;
      4'b1111: AluOut = (Op2 == 0) ? 32'hFFFF_FFFF : Op1 / Op2;
      default: AluOut = 32'hDEAD_BEEF;
    endcase
  end
  assign AluZF = (AluOut == 0);

  // Reference: what the response must be, derived from the op's meaning.
  function automatic void ref_op(input logic [1:0] op, input logic [5:0] f,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic zf,
                                 output logic ill, output logic dz,
                                 output int lat, output logic [3:0] sel);
    ill = 1'b0; dz = 1'b0; lat = 1; r = '0; sel = 4'b0000;
    if (op == 2'b00)      begin r = a + b; sel = 4'b0010; end
    else if (op == 2'b01) begin r = a - b; sel = 4'b0110; end
    else if (op == 2'b10) begin
      if (f == 6'h20)      begin r = a + b; sel = 4'b0010; end
      else if (f == 6'h22) begin r = a - b; sel = 4'b0110; end
      else if (f == 6'h24) begin r = a & b; sel = 4'b0000; end
      else if (f == 6'h25) begin r = a | b; sel = 4'b0001; end
      else if (f == 6'h2a) begin r = ($signed(a) < $signed(b)) ? 1 : 0; sel = 4'b0111; end
      else if (f == 6'h18) begin r = a * b; sel = 4'b0101; lat = MUL; end
      else if (f == 6'h1a) begin
        sel = 4'b1111;
        if (b == 0) begin r = 32'hFFFF_FFFF; dz = 1'b1; end
        else begin r = a / b; lat = DIV; end
      end
      else ill = 1'b1;
    end
    else ill = 1'b1;
    zf = dz ? 1'b0 : (r == 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ReqReady && n < 20) begin tick(); n++; end
    nvec++;
    if (!ReqReady) begin
      nerr++;
      $display("FAIL %s ready_timeout actual=0 required=1", name);
    end
  endtask

  // One request through its complete life cycle, followed by the checks.
  task automatic run_op(input logic [1:0] op, input logic [5:0] f,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input bit pulse, input string name);
    logic [W-1:0] er; logic ezf, eill, edz; int elat; logic [3:0] esel;
    logic [W-1:0] op1_s, op2_s, r_s; logic [3:0] sel_s;
    int k; bit moved;
    ref_op(op, f, a, b, er, ezf, eill, edz, elat, esel);
    ALUOp = op; Funct = f; A = a; B = b; ReqValid = 1'b1; RspReady = 1'b0;
    wait_ready(name);
    tick();                                      // accept edge
    ReqValid = 1'b0;
    if (pulse) begin ReqValid = 1'b1; A = ~a; B = ~b; end
    op1_s = Op1; op2_s = Op2; sel_s = Sel;
    nvec++;
    if (Sel !== esel || Op2 !== (eill ? '0 : b) || (!eill && Op1 !== a)) begin
      nerr++;
      $display("FAIL %s operands actual=%h/%h/%h required=%h/%h/%h",
               name, Op1, Op2, Sel, a, eill ? '0 : b, esel);
    end
    k = 0; moved = 0;
    while (!RspValid && k < 60) begin
      tick(); k++;
      ReqValid = 1'b0;
      if (Op1 !== op1_s || Op2 !== op2_s || Sel !== sel_s) moved = 1;
    end
    nvec++;
    if (k !== elat) begin
      nerr++;
      $display("FAIL %s latency actual=%0d required=%0d", name, k, elat);
    end
    nvec++;
    if (Result !== er || ZF !== ezf || IllegalOp !== eill || DivZero !== edz) begin
      nerr++;
      $display("FAIL %s response actual=%h zf%b ill%b dz%b required=%h zf%b ill%b dz%b",
               name, Result, ZF, IllegalOp, DivZero, er, ezf, eill, edz);
    end
    r_s = Result;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (!RspValid || Result !== r_s || Op1 !== op1_s || Op2 !== op2_s || Sel !== sel_s) moved = 1;
    end
    RspReady = 1'b1;
    tick();
    RspReady = 1'b0;
    if (Op1 !== op1_s || Op2 !== op2_s || Sel !== sel_s) moved = 1;
    nvec++;
    if (moved) begin
      nerr++;
      $display("FAIL %s held_stable actual=moved required=stable", name);
    end
    nvec++;
    if (RspValid !== 1'b0 || ReqReady !== 1'b1) begin
      nerr++;
      $display("FAIL %s retire actual=rv%b rr%b required=rv0 rr1", name, RspValid, ReqReady);
    end
    if (pulse) begin
      tick(); tick();
      nvec++;
      if (RspValid !== 1'b0 || Op1 !== op1_s) begin
        nerr++;
        $display("FAIL %s pulse_not_latched actual=rv%b op1=%h required=rv0 op1=%h",
                 name, RspValid, Op1, op1_s);
      end
    end
  endtask

  task automatic check_zero_state(input string name);
    nvec++;
    if (ReqReady !== 1'b1 || RspValid !== 1'b0 || Op1 !== '0 || Op2 !== '0 ||
        Sel !== 4'b0000 || Result !== '0 || ZF !== 1'b0 || IllegalOp !== 1'b0 ||
        DivZero !== 1'b0) begin
      nerr++;
      $display("FAIL %s actual=rr%b rv%b %h %h %h %h zf%b ill%b dz%b required=rr1 rv0 all zero",
               name, ReqReady, RspValid, Op1, Op2, Sel, Result, ZF, IllegalOp, DivZero);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ReqValid = 1'b0; RspReady = 1'b0;
    ALUOp = 2'b00; Funct = '0; A = '0; B = '0;
    tick(); tick();
    reset = 1'b0;
    check_zero_state("reset_state");
  endtask

  task automatic test_sub_hold();
    run_op(2'b10, 6'b100010, 32'd5, 32'd5, 3, 1'b0, "sub_5_5_hold");
  endtask

  task automatic test_mul();
    run_op(2'b10, 6'b011000, 32'd7, 32'd6, 0, 1'b0, "mul_7_6");
  endtask

  task automatic test_reset_mid_mul();
    ALUOp = 2'b10; Funct = 6'b011000; A = 32'd3; B = 32'd9; ReqValid = 1'b1;
    wait_ready("rst_mul");
    tick();                    // accept, cnt=3
    ReqValid = 1'b0;
    tick();                    // cnt=2
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_zero_state("reset_mid_mul");
  endtask

  task automatic test_divzero();
    run_op(2'b10, 6'b011010, 32'd9, 32'd0, 1, 1'b0, "div_9_0");
    run_op(2'b00, 6'b000000, 32'd1, 32'd2, 0, 1'b0, "add_after_div0");
    run_op(2'b10, 6'b011010, 32'd100, 32'd7, 0, 1'b0, "div_100_7");
  endtask

  task automatic test_illegal();
    run_op(2'b11, 6'b100000, 32'h1234_5678, 32'h0F0F_0F0F, 2, 1'b1, "illegal_aluop11");
    run_op(2'b10, 6'b111111, 32'hFFFF_0000, 32'hFFFF_FFFF, 0, 1'b1, "illegal_funct");
    run_op(2'b10, 6'b011010, 32'd50, 32'd5, 0, 1'b1, "div_pulse");
  endtask

  task automatic test_random();
    logic [5:0] tbl [7];
    logic [1:0] op; logic [5:0] f; logic [W-1:0] a, b;
    tbl[0] = 6'h20; tbl[1] = 6'h22; tbl[2] = 6'h24; tbl[3] = 6'h25;
    tbl[4] = 6'h2a; tbl[5] = 6'h18; tbl[6] = 6'h1a;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) f = 6'($urandom);
      else f = tbl[$urandom_range(0, 6)];
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a = a & 32'hFF;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = a;
        2:       b = $urandom & 32'hF;
        default: b = $urandom;
      endcase
      run_op(op, f, a, b, $urandom_range(0, 2), 1'b0, "random");
    end
  endtask

  task automatic test_back_to_back();
    int nacc = 0, nrsp = 0, t = 0;
    int t_rsp [2];
    logic [W-1:0] r_rsp [2];
    bit acc;
    int gap_req;
`ifdef ALU_ISSUE_PIPE_EN
    gap_req = 2;
`else
    gap_req = 3;
`endif
    t_rsp[0] = 0; t_rsp[1] = 0; r_rsp[0] = '0; r_rsp[1] = '0;
    ALUOp = 2'b00; Funct = '0; A = 32'd1; B = 32'd1;
    ReqValid = 1'b1; RspReady = 1'b1;
    while (nrsp < 2 && t < 30) begin
      acc = ReqValid && ReqReady;
      tick(); t++;
      if (acc) begin
        nacc++;
        if (nacc == 1) begin ALUOp = 2'b10; Funct = 6'b101010; A = 32'd2; B = 32'd3; end
        else ReqValid = 1'b0;
      end
      if (RspValid) begin
        t_rsp[nrsp] = t; r_rsp[nrsp] = Result; nrsp++;
      end
    end
    ReqValid = 1'b0; RspReady = 1'b0;
    tick(); tick();
    nvec++;
    if (nrsp !== 2) begin
      nerr++;
      $display("FAIL b2b_count actual=%0d required=2", nrsp);
    end
    nvec++;
    if (r_rsp[0] !== 32'd2 || r_rsp[1] !== 32'd1) begin
      nerr++;
      $display("FAIL b2b_results actual=%0d,%0d required=2,1", r_rsp[0], r_rsp[1]);
    end
    nvec++;
    if (t_rsp[1] - t_rsp[0] !== gap_req) begin
      nerr++;
      $display("FAIL b2b_spacing actual=%0d required=%0d", t_rsp[1] - t_rsp[0], gap_req);
    end
  endtask

  initial begin
    test_reset();
    test_sub_hold();
    test_mul();
    test_reset_mid_mul();
    test_divzero();
    test_illegal();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
